simple_axi_slave_mem: RTL
=========================

SIMPLE_AXI_SLAVE_MEM -- requirements
Module: simple_axi_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning memory size in 64-bit words; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0; it SHALL be 8-byte aligned.
REQ-003 The block SHALL have parameter LATENCY, default 1, range 0..15, meaning the extra cycles inserted before asserting bvalid or rvalid.
REQ-004 The block SHALL have: i_clk  in  1  clock, rising edge.
REQ-005 The block SHALL have: i_rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have: s_axi_awvalid in 1, s_axi_awready out 1, s_axi_awaddr in 32, s_axi_awsize in 3  (write address channel).
REQ-007 The block SHALL have: s_axi_wvalid in 1, s_axi_wready out 1, s_axi_wlast in 1, s_axi_wdata in 64, s_axi_wstrb in 8  (write data channel).
REQ-008 The block SHALL have: s_axi_bvalid out 1, s_axi_bready in 1, s_axi_bresp out 2  (write response channel).
REQ-009 The block SHALL have: s_axi_arvalid in 1, s_axi_arready out 1, s_axi_araddr in 32, s_axi_arsize in 3  (read address channel).
REQ-010 The block SHALL have: s_axi_rvalid out 1, s_axi_rready in 1, s_axi_rlast out 1, s_axi_rdata out 64, s_axi_rresp out 2  (read data channel).

Function
REQ-011 The block SHALL support single-beat transfers only; a handshake is valid and ready high at the same rising edge.
REQ-012 The write FSM SHALL have states WR_ADDR, WR_DATA, WR_WAIT and WR_RESP.
REQ-013 In WR_ADDR: awready=1; on AW handshake, capture awaddr and awsize and go to WR_DATA.
REQ-014 In WR_DATA: wready=1; on W handshake, commit the write and go to WR_WAIT, or directly to WR_RESP when LATENCY=0.
REQ-015 In WR_WAIT: a down-counter loaded with LATENCY-1 SHALL decrement each cycle; go to WR_RESP when it reaches 0.
REQ-016 In WR_RESP: bvalid=1 with bresp held stable; on bready, go to WR_ADDR; AW SHALL NOT be accepted before that.
REQ-017 The read FSM SHALL have states RD_ADDR, RD_WAIT and RD_RESP.
REQ-018 In RD_ADDR: arready=1; on AR handshake, register the memory word and response, then go to RD_WAIT (LATENCY>0) or RD_RESP.
REQ-019 In RD_RESP: rvalid=1 and rlast=1; rdata and rresp SHALL stay stable until rready; on rready, go to RD_ADDR.
REQ-020 Minimum latency SHALL be: W handshake to bvalid = 1+LATENCY cycles; AR handshake to rvalid = 1+LATENCY cycles.
REQ-021 Address decode: in range means BASE_ADDR <= addr < BASE_ADDR + DEPTH*8; word index = (addr - BASE_ADDR) >> 3.
REQ-022 Response priority SHALL be: out of range gives DECERR (2'b11); else size > 3 or misaligned for its size gives SLVERR (2'b10); else, for writes only, wlast=0 gives SLVERR; else OKAY (2'b00).
REQ-023 A non-OKAY write SHALL NOT modify memory; an OKAY write SHALL update only the byte lanes with wstrb[i]=1; wstrb SHALL be used as given, with no re-shifting by address.
REQ-024 A non-OKAY read SHALL return rdata=0; an OKAY read SHALL return the full 64-bit word, and the master performs the lane extraction.
REQ-025 The read and write channels SHALL be independent; a write commit and a read capture at the same edge and index SHALL return the old data.
REQ-026 Address offset arithmetic SHALL be 32-bit unsigned; an addr below BASE_ADDR SHALL decode as out of range, with no wrap-around.

Reset
REQ-027 While i_rstn=0: awready, wready, bvalid, arready, rvalid and rlast SHALL be 0; bresp, rresp and rdata SHALL be 0; FSMs SHALL be in WR_ADDR and RD_ADDR; counters SHALL be 0.
REQ-028 Readies SHALL rise on the first rising edge after reset deassertion.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset during any state SHALL abort the transfer; a pending write not yet committed SHALL be dropped.

Structure
REQ-031 The resp enum (OKAY/EXOKAY/SLVERR/DECERR) and size enum (BYTE/HALF/WORD/DWORD) SHALL live in shared package simple_axi_pkg, together with DATA_W=64 and ADDR_W=32; the master SHALL use the same package.
REQ-032 The storage SHALL be sub-module simple_axi_mem_array: DEPTH x 64 bits, one byte-enabled write port and one synchronous read port, no reset.

Verification
REQ-033 Write 0x1122334455667788 to 0x10 with size=3 and wstrb=0xFF, then read 0x10 -> bresp=OKAY, rdata=0x1122334455667788, rresp=OKAY, rlast=1.
REQ-034 Partial write 0xAB to 0x13 with size=0 and wstrb=0x08 over the previous word, then read 0x10 -> rdata=0x11223344AB667788.
REQ-035 Read 0x0000_0800 with DEPTH=256 and BASE=0 -> rresp=DECERR, rdata=0; write there -> bresp=DECERR, memory unchanged.
REQ-036 Hold bready=0 for 5 cycles with LATENCY=3 -> bvalid rises 4 cycles after the W handshake, bresp stable, awready=0 until bready.
REQ-037 A write to 0x20 and a read of 0x20 with the same handshake edge -> old data returned, new data visible on the next read.
REQ-038 Drive the slave from the simple_axi_master through write/read of 0x8 with size=2 -> o_done=1, o_error=0, o_rdata equals the written value.

Source files
------------

// File: rtl/simple_axi_pkg.sv
// Shared AXI types for the simple slave memory and its master.
// Holds resp/size enums, bus widths, FSM states and address decode.
package simple_axi_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } size_e;

  typedef enum logic [1:0] {
    WR_ADDR,
    WR_DATA,
    WR_WAIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_ADDR,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  // Range first, then size/alignment; no wrap below base.
  function automatic resp_e decode_resp(
    input logic [ADDR_W-1:0] addr,
    input logic [2:0]        size,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W:0]   span
  );
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] mask;
    off = addr - base;
    if (addr < base || {1'b0, off} >= span)
      return RESP_DECERR;
    if (size > 3'd3)
      return RESP_SLVERR;
    mask = (32'd1 << size) - 32'd1;
    if ((addr & mask) != '0)
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/simple_axi_slave_mem_array.sv
// DEPTH x 64-bit storage, byte-enabled write, synchronous read.
// Ports: write (we/wstrb/widx/wdata), read (re/ridx) -> o_rdata.
module simple_axi_mem_array
  import simple_axi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Same-edge write and read at one index returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (i_wstrb[i])
          mem_q[i_widx][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    if (i_re)
      rdata_q <= mem_q[i_ridx];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/simple_axi_slave_mem.sv
// Single-beat AXI slave memory with independent read/write FSMs.
// Ports: i_clk, i_rstn, AXI AW/W/B/AR/R channels (64-bit data).
module simple_axi_slave_mem
  import simple_axi_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awsize,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic              s_axi_wlast,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arsize,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              s_axi_rlast,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SPAN_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] SPAN =
    SPAN_W'(longint'(DEPTH) * 64'd8);
  localparam logic [3:0] LAT_LOAD =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  resp_e             bresp_q, bresp_d;

  rd_state_e         rd_state_q, rd_state_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  resp_e             rresp_q, rresp_d;

  logic              aw_hs, w_hs, b_hs;
  logic              ar_hs, r_hs;
  resp_e             aw_resp, w_resp, ar_resp;
  logic              mem_we;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid & wready_q;
  assign b_hs  = bvalid_q & s_axi_bready;
  assign ar_hs = s_axi_arvalid & arready_q;
  assign r_hs  = rvalid_q & s_axi_rready;

  assign aw_resp = decode_resp(aw_addr_q, aw_size_q,
                               BASE_ADDR, SPAN);
  // A missing wlast only matters once address/size are clean.
  assign w_resp  = (aw_resp == RESP_OKAY && !s_axi_wlast)
                   ? RESP_SLVERR : aw_resp;
  assign ar_resp = decode_resp(s_axi_araddr, s_axi_arsize,
                               BASE_ADDR, SPAN);

  assign mem_we = w_hs && (w_resp == RESP_OKAY);
  assign w_idx  = IDX_W'((aw_addr_q - BASE_ADDR) >> 3);
  assign r_idx  = IDX_W'((s_axi_araddr - BASE_ADDR) >> 3);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_addr_d  = aw_addr_q;
    aw_size_d  = aw_size_q;
    wr_cnt_d   = wr_cnt_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      WR_ADDR: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          aw_addr_d  = s_axi_awaddr;
          aw_size_d  = s_axi_awsize;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          wready_d = 1'b0;
          bresp_d  = w_resp;
          if (LATENCY == 0) begin
            bvalid_d   = 1'b1;
            wr_state_d = WR_RESP;
          end else begin
            wr_cnt_d   = LAT_LOAD;
            wr_state_d = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = WR_ADDR;
        end
      end
      default: wr_state_d = WR_ADDR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_state_q <= WR_ADDR;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      wr_cnt_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_size_q  <= aw_size_d;
      wr_cnt_q   <= wr_cnt_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_ADDR: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rresp_d   = ar_resp;
          if (LATENCY == 0) begin
            rvalid_d   = 1'b1;
            rd_state_d = RD_RESP;
          end else begin
            rd_cnt_d   = LAT_LOAD;
            rd_state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_ADDR;
        end
      end
      default: rd_state_d = RD_ADDR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_state_q <= RD_ADDR;
      rd_cnt_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  simple_axi_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_wstrb (s_axi_wstrb),
    .i_widx  (w_idx),
    .i_wdata (s_axi_wdata),
    .i_re    (ar_hs),
    .i_ridx  (r_idx),
    .o_rdata (mem_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  // Error reads and idle/reset cycles drive zero data.
  assign s_axi_rdata   = (rvalid_q && rresp_q == RESP_OKAY)
                         ? mem_rdata : '0;

endmodule
